// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution / prediction blocks:
// BrOp field layout, conditional funct3 codes, 2-bit counter states.
package branch_pkg;

  // BrOp layout: [4] = jump, [3] = conditional, [2:0] = funct3
  localparam int BROP_W    = 5;
  localparam int BROP_JUMP = 4;
  localparam int BROP_COND = 3;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Move one step towards strongly-taken, holding at ST
  function automatic logic [1:0] satInc(input logic [1:0] c);
    if (c == ST) return c;
    return c + 2'd1;
  endfunction

  // Move one step towards strongly-not-taken, holding at SNT
  function automatic logic [1:0] satDec(input logic [1:0] c);
    if (c == SNT) return c;
    return c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation from the 5-bit BrOp.
// Shared with the single-cycle datapath.
module branch_cond
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      brop,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            taken
);

  // Jumps always taken; conditionals decided by funct3; everything else not taken
  always_comb begin
    taken = 1'b0;
    if (brop[BROP_JUMP]) begin
      taken = 1'b1;
    end else if (brop[BROP_COND]) begin
      case (brop[2:0])
        F3_BEQ:  taken = (a == b);
        F3_BNE:  taken = (a != b);
        F3_BLT:  taken = ($signed(a) <  $signed(b));
        F3_BGE:  taken = ($signed(a) >= $signed(b));
        F3_BLTU: taken = (a <  b);
        F3_BGEU: taken = (a >= b);
        default: taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Pipelined branch unit: IF-stage direction prediction from a 2-bit BHT,
// EX-stage resolution with a registered redirect, and saturating statistics.
//
// Handshake: ex_valid qualifies every ex_* input for exactly one cycle; there
// is no back-pressure. res_valid/res_mispredict are the registered copy of
// that qualifier one cycle later; res_taken/res_redirect_pc only change when
// a valid instruction resolves and otherwise hold.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int PRED_MODE = 1,
  parameter int CNT_W     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic [4:0]      ex_brop,
  input  logic [XLEN-1:0] ex_a,
  input  logic [XLEN-1:0] ex_b,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            res_valid,
  output logic            res_taken,
  output logic            res_mispredict,
  output logic [XLEN-1:0] res_redirect_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic            exTaken;
  logic            isBranch;
  logic            mispredict;
  logic [XLEN-1:0] redirectPc;

  branch_cond #(.XLEN(XLEN)) uCond (
    .brop  (ex_brop),
    .a     (ex_a),
    .b     (ex_b),
    .taken (exTaken)
  );

  // EX-stage classification and correct next PC (pc+4 wraps naturally)
  always_comb begin
    isBranch   = ex_brop[BROP_JUMP] | ex_brop[BROP_COND];
    mispredict = ex_valid && (exTaken != ex_pred_taken);
    redirectPc = exTaken ? ex_target : (ex_pc + XLEN'(4));
  end

  // Registered resolution; taken/redirect hold when EX is empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid       <= 1'b0;
      res_taken       <= 1'b0;
      res_mispredict  <= 1'b0;
      res_redirect_pc <= '0;
    end else begin
      res_valid      <= ex_valid;
      res_mispredict <= mispredict;
      if (ex_valid) begin
        res_taken       <= exTaken;
        res_redirect_pc <= redirectPc;
      end
    end
  end

  // Saturating branch and mispredict counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (ex_valid && isBranch && (stat_branches != '1))
        stat_branches <= stat_branches + CNT_W'(1);
      if (mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
    end
  end

  generate
    if (PRED_MODE == 1) begin : gBht
      logic [1:0]       bht [BHT_DEPTH];
      logic [IDX_W-1:0] ifIdx;
      logic [IDX_W-1:0] exIdx;
      logic             unusedPcBits;

      assign ifIdx         = if_pc[IDX_W+1:2];
      assign exIdx         = ex_pc[IDX_W+1:2];
      // Read is the pre-update value on a same-index write; no bypass
      assign if_pred_taken = bht[ifIdx][1];
      assign unusedPcBits  = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

      // Train the indexed counter on every valid jump/conditional
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= WNT;
        end else if (ex_valid && isBranch) begin
          bht[exIdx] <= exTaken ? satInc(bht[exIdx]) : satDec(bht[exIdx]);
        end
      end
    end else begin : gStatic
      logic unusedPcBits;
      assign unusedPcBits  = ^if_pc;
      assign if_pred_taken = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit: main (BHT) instance, a static
// not-taken instance and a narrow-counter instance share one stimulus stream.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        ex_valid;
  logic [4:0]  ex_brop;
  logic [31:0] ex_a, ex_b, ex_pc, ex_target;
  logic        ex_pred_taken;

  // main instance
  logic        predMain, resValid, resTaken, resMis;
  logic [31:0] resRedirect, statB, statM;
  // static instance
  logic        predStatic, rvS, rtS, rmS;
  logic [31:0] rpS, statBS, statMS;
  // CNT_W=4 instance
  logic        predSmall, rvN, rtN, rmN;
  logic [31:0] rpN;
  logic [3:0]  statBN, statMN;

  int errors = 0;
  int checks = 0;
  int expBranches = 0;
  int expMis = 0;
  logic [31:0] exp_q[$];

  branch_predict_unit dutMain (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(predMain),
    .ex_valid(ex_valid), .ex_brop(ex_brop), .ex_a(ex_a), .ex_b(ex_b),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .res_valid(resValid), .res_taken(resTaken), .res_mispredict(resMis),
    .res_redirect_pc(resRedirect), .stat_branches(statB), .stat_mispredicts(statM)
  );

  branch_predict_unit #(.PRED_MODE(0)) dutStatic (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(predStatic),
    .ex_valid(ex_valid), .ex_brop(ex_brop), .ex_a(ex_a), .ex_b(ex_b),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .res_valid(rvS), .res_taken(rtS), .res_mispredict(rmS),
    .res_redirect_pc(rpS), .stat_branches(statBS), .stat_mispredicts(statMS)
  );

  branch_predict_unit #(.CNT_W(4)) dutSmall (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(predSmall),
    .ex_valid(ex_valid), .ex_brop(ex_brop), .ex_a(ex_a), .ex_b(ex_b),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .res_valid(rvN), .res_taken(rtN), .res_mispredict(rmN),
    .res_redirect_pc(rpN), .stat_branches(statBN), .stat_mispredicts(statMN)
  );

  // clock
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    ex_valid = 1'b0; ex_brop = '0; ex_a = '0; ex_b = '0;
    ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0; if_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expBranches = 0;
    expMis = 0;
    exp_q.delete();
  endtask

  // Drive one EX instruction, then check the main instance one edge later
  task automatic driveEx(input string tag, input logic [4:0] brop,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] target,
                         input logic pred, input logic expTaken);
    logic expMisBit;
    @(negedge clk);
    ex_valid = 1'b1; ex_brop = brop; ex_a = a; ex_b = b;
    ex_pc = pc; ex_target = target; ex_pred_taken = pred;
    expMisBit = (expTaken != pred);
    exp_q.push_back(expTaken ? target : pc + 32'd4);
    if (brop[4] || brop[3]) expBranches++;
    if (expMisBit) expMis++;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    checkVal({tag, ".valid"}, 32'(resValid), 32'd1);
    checkVal({tag, ".taken"}, 32'(resTaken), 32'(expTaken));
    checkVal({tag, ".mispredict"}, 32'(resMis), 32'(expMisBit));
    checkVal({tag, ".redirect"}, resRedirect, exp_q.pop_front());
    checkVal({tag, ".statBranches"}, statB, 32'(expBranches));
    checkVal({tag, ".statMispredicts"}, statM, 32'(expMis));
  endtask

  task automatic checkPred(input string tag, input logic [31:0] pc, input logic exp);
    if_pc = pc;
    #1;
    checkVal(tag, 32'(predMain), 32'(exp));
  endtask

  initial begin
    doReset();

    // Test 1: reset prediction, BEQ taken mispredict, counter 01->10
    checkVal("reset.resValid", 32'(resValid), 32'd0);
    checkVal("reset.redirect", resRedirect, 32'd0);
    checkVal("reset.statB", statB, 32'd0);
    checkPred("t1.predBefore", 32'h100, 1'b0);
    driveEx("t1.beq", 5'b01000, 32'd5, 32'd5, 32'h100, 32'h200, 1'b0, 1'b1);
    checkPred("t1.predAfter", 32'h100, 1'b1);
    // idle cycle: valid/mispredict drop, taken/redirect hold
    @(posedge clk); #1;
    checkVal("idle.valid", 32'(resValid), 32'd0);
    checkVal("idle.mispredict", 32'(resMis), 32'd0);
    checkVal("idle.takenHold", 32'(resTaken), 32'd1);
    checkVal("idle.redirectHold", resRedirect, 32'h200);

    // Test 2: signed vs unsigned less-than
    driveEx("t2.blt", 5'b01100, 32'hFFFFFFFE, 32'd1, 32'h104, 32'h400, 1'b1, 1'b1);
    driveEx("t2.bltu", 5'b01110, 32'hFFFFFFFE, 32'd1, 32'h104, 32'h400, 1'b1, 1'b0);
    driveEx("t2.bge", 5'b01101, 32'd1, 32'hFFFFFFFE, 32'h104, 32'h480, 1'b0, 1'b1);
    driveEx("t2.bgeu", 5'b01111, 32'd1, 32'hFFFFFFFE, 32'h104, 32'h480, 1'b0, 1'b0);
    driveEx("t2.f3_010", 5'b01010, 32'd3, 32'd3, 32'h104, 32'h480, 1'b0, 1'b0);

    // Test 3: counter saturation at index of 0x108
    for (int i = 0; i < 5; i++)
      driveEx("t3.nt", 5'b01001, 32'd7, 32'd7, 32'h108, 32'h500, 1'b0, 1'b0);
    checkPred("t3.sat00", 32'h108, 1'b0);
    driveEx("t3.t1", 5'b01001, 32'd7, 32'd8, 32'h108, 32'h500, 1'b0, 1'b1);
    checkPred("t3.after1Taken", 32'h108, 1'b0);
    driveEx("t3.t2", 5'b01001, 32'd7, 32'd8, 32'h108, 32'h500, 1'b0, 1'b1);
    checkPred("t3.after2Taken", 32'h108, 1'b1);
    for (int i = 0; i < 4; i++)
      driveEx("t3.tmore", 5'b01001, 32'd7, 32'd8, 32'h108, 32'h500, 1'b1, 1'b1);
    driveEx("t3.nt11", 5'b01001, 32'd7, 32'd7, 32'h108, 32'h500, 1'b1, 1'b0);
    checkPred("t3.sat11", 32'h108, 1'b1);
    driveEx("t3.nt10", 5'b01001, 32'd7, 32'd7, 32'h108, 32'h500, 1'b1, 1'b0);
    checkPred("t3.back01", 32'h108, 1'b0);

    // Test 4: aliased non-branch at top of memory, redirect wraps
    driveEx("t4.nonbr", 5'b00000, 32'd0, 32'd0, 32'hFFFFFFFC, 32'h600, 1'b1, 1'b0);
    checkPred("t4.bhtUnchanged", 32'hFFFFFFFC, 1'b0);

    // Test 6a: asynchronous reset mid-stream
    driveEx("t6.jal", 5'b10000, 32'd0, 32'd0, 32'h100, 32'h700, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkVal("rst.valid", 32'(resValid), 32'd0);
    checkVal("rst.taken", 32'(resTaken), 32'd0);
    checkVal("rst.mispredict", 32'(resMis), 32'd0);
    checkVal("rst.redirect", resRedirect, 32'd0);
    checkVal("rst.statB", statB, 32'd0);
    checkVal("rst.statM", statM, 32'd0);
    checkVal("rst.smallStatB", 32'(statBN), 32'd0);
    checkPred("rst.bht", 32'h100, 1'b0);
    doReset();

    // Test 5: static mode never predicts taken; 10 JALs all mispredict
    for (int i = 0; i < 10; i++)
      driveEx("t5.jal", 5'b10000, 32'd0, 32'd0, 32'h200, 32'h800, 1'b0, 1'b1);
    if_pc = 32'h200; #1;
    checkVal("t5.staticPred", 32'(predStatic), 32'd0);
    checkVal("t5.staticMis", statMS, 32'd10);
    checkVal("t5.staticBr", statBS, 32'd10);
    checkVal("t5.mainPred", 32'(predMain), 32'd1);
    checkVal("t5.smallBr", 32'(statBN), 32'd10);

    // Test 6b: 4-bit counters saturate at 15 after 20 branches
    for (int i = 0; i < 10; i++)
      driveEx("t6.jal2", 5'b10000, 32'd0, 32'd0, 32'h200, 32'h800, 1'b1, 1'b1);
    checkVal("t6.smallBrSat", 32'(statBN), 32'd15);
    checkVal("t6.smallMis", 32'(statMN), 32'd10);
    checkVal("t6.staticBr", statBS, 32'd20);
    checkVal("t6.staticPred", 32'(predStatic), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
